dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port 19-bit data memory between the pipeline's memory stage (CPU port) and a debug/loader port (DBG port). It sits between `memory_write_cycle` and `data_memeory`. Arbitration is CPU-priority with a bounded-starvation guarantee for DBG, plus a DBG lock mode for atomic multi-access sequences. When the CPU loses arbitration, `cpu_stall` freezes the pipeline.

## Interface
- `DATA_W`, 19, data width
- `ADDR_W`, 19, address width
- `MAX_WAIT`, 4, number of consecutive cycles DBG may be denied before it beats CPU (≥1)
- `MAX_LOCK`, 8, maximum number of accesses in one locked DBG sequence
- `clk` in 1, single clock; all state changes on its rising edge
- `rst` in 1, reset, asynchronous, active-low
- `cpu_req` in 1, memory-stage access request
- `cpu_we` in 1, CPU write enable
- `cpu_addr` in ADDR_W, CPU address
- `cpu_wdata` in DATA_W, CPU write data
- `cpu_gnt` out 1, CPU access issued this cycle
- `cpu_stall` out 1, equals `cpu_req & ~cpu_gnt`
- `cpu_rvalid` out 1, CPU read data valid
- `cpu_rdata` out DATA_W, CPU read data
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same meanings, DBG port
- `dbg_lock` in 1, keep DBG ownership after the current grant
- `mem_en` out 1, memory access strobe
- `mem_we` out 1, memory write enable
- `mem_addr` out ADDR_W, memory address
- `mem_wdata` out DATA_W, memory write data
- `mem_rdata` in DATA_W, memory read data, one-cycle synchronous latency

## Operation
- **FSM states:** ARB, LOCKED. Reset state is ARB.
- **Winner in ARB, combinational in the issue cycle T:**
  - DBG wins if `dbg_req & (~cpu_req | wait_cnt == MAX_WAIT)`.
  - Otherwise CPU wins if `cpu_req`.
  - Otherwise there is no access.
- **Winner in LOCKED:**
  - Only DBG is served.
  - `cpu_gnt` = 0, so `cpu_stall` = `cpu_req`.
- **Memory drive:** the `mem_*` outputs are muxed from the winner's inputs. `mem_en` = `cpu_gnt | dbg_gnt`. When there is no winner, `mem_we` = 0.
- **Grant outputs:** `cpu_gnt` and `dbg_gnt` are mutually exclusive, and each is high only if its request is high.
- **Requester rule:** a request stays asserted with stable address and data until the cycle its grant is high. A request that is still high in the cycle after its grant is a new access, so back-to-back accesses are legal.
- **wait_cnt** (saturates at MAX_WAIT):
  - increments on each cycle with `dbg_req & ~dbg_gnt`;
  - clears on `dbg_gnt`;
  - clears when `dbg_req` is low.
- **ARB→LOCKED:** on `dbg_gnt & dbg_lock`. `lock_cnt` is loaded with 1.
- **Inside LOCKED:**
  - each `dbg_gnt` increments `lock_cnt`;
  - the FSM returns to ARB when `dbg_lock` is low at a clock edge, or after the access that makes `lock_cnt == MAX_LOCK`;
  - `wait_cnt` is held at 0.
- **Idle lock:** in LOCKED with `dbg_req` low and `dbg_lock` high, the memory idles and the CPU stays stalled. This is intended.
- **Read return:**
  - A registered owner flag records which port issued in cycle T, read or write.
  - At T+1 that port's `rvalid` = 1 and its `rdata` = `mem_rdata`. The other port's `rdata` holds its last value.
  - Writes also produce `rvalid`, which is used as a write acknowledge. `rdata` is don't-care for writes.
- **Reset (`rst` low), at any time, asynchronously:**
  - returns the FSM to ARB and clears `wait_cnt`, `lock_cnt`, the owner flag, both `rvalid` outputs and both `rdata` outputs;
  - drops any in-flight read return.
  - Combinational outputs follow their inputs. During reset all grants, `mem_en` and `mem_we` are forced to 0.

## Timing
- Issue-to-data latency is 1 cycle: grant at T, `rvalid` at T+1.
- Sustained throughput is 1 access per cycle, shared between the ports.
- DBG's worst-case wait outside LOCKED is MAX_WAIT+1 cycles from `req` to `gnt`.
- CPU's worst-case stall is MAX_LOCK+MAX_WAIT+1 cycles, provided DBG keeps requesting while locked.
- Write at T then read of the same address at T+1: the read returns the written data at T+2.
- **Simultaneous events:**
  - A lock release edge coinciding with `dbg_gnt`: that grant completes, and ARB applies from the next cycle.
  - Hitting MAX_LOCK while `dbg_lock` is still high: the FSM returns to ARB, and `dbg_lock` must fall before a new lock can be taken. The FSM uses an edge-qualified re-lock flag.

## Structure
- **Shared package `cpu_pkg`:** DATA_W/ADDR_W constants (19), the FSM state encoding `ARB=1'b0`, `LOCKED=1'b1`, and the owner encoding `OWN_CPU`/`OWN_DBG`.
- **One sub-module:** `arb_wait_counter`, a saturating counter with clear and enable, instantiated for both `wait_cnt` and `lock_cnt`.
- The top-level instantiates the arbiter in `pipeline_top` between `memory_write_cycle` and `data_memeory`.

## Test plan
- **Reset:** `rst`=0 mid-access with CPU read granted → all outputs 0; after release, no `rvalid` for the dropped read.
- **CPU only:** write 0x1ABCD to addr 5 at T, read addr 5 at T+1 → `cpu_stall`=0 throughout; `cpu_rdata`=0x1ABCD with `cpu_rvalid` at T+2.
- **Contention:** `cpu_req` held continuously, `dbg_req` raised at T, MAX_WAIT=4 → `cpu_gnt` T..T+3, `dbg_gnt` at T+4, `cpu_stall` high only at T+4.
- **DBG idle path:** `cpu_req`=0, `dbg_req` read addr 9 → `dbg_gnt` same cycle, `dbg_rvalid` next cycle with memory contents; `cpu_rvalid` stays 0.
- **Lock:** `dbg_lock` high for 3 DBG writes while `cpu_req` high → CPU stalled 3 cycles, CPU granted the cycle after `dbg_lock` falls.
- **Lock cap:** MAX_LOCK=8, `dbg_lock` held for 12 requests → exactly 8 DBG grants, then the FSM returns to ARB and CPU is granted; no re-lock until `dbg_lock` toggles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and encodings used by the data-memory arbiter.
package cpu_pkg;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 19;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter; a clear and an enable in the same cycle restart the
// count at 1, which lets a first event load the counter directly.
module arb_wait_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d, base;

  always_comb begin
    base  = clr ? '0 : cnt_q;
    cnt_d = base;
    if (en && (base != W'(MAX))) cnt_d = base + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage and the
// debug port: CPU priority, bounded DBG starvation, and a DBG lock mode.
module dmem_arbiter #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import cpu_pkg::*;

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);

  arb_state_e        state_q, state_d;
  logic              relock_blk_q, relock_blk_d;
  logic              pend_q, pend_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [WW-1:0]     wait_cnt;
  logic [LW-1:0]     lock_cnt;
  logic              locked;

  assign locked = (state_q == LOCKED);

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      if (locked)
        dbg_gnt = dbg_req;
      else if (dbg_req && (!cpu_req || wait_cnt == WW'(MAX_WAIT)))
        dbg_gnt = 1'b1;
      else if (cpu_req)
        cpu_gnt = 1'b1;
    end
    cpu_stall = cpu_req & ~cpu_gnt;
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = dbg_gnt ? dbg_we : (cpu_gnt & cpu_we);
    mem_addr  = dbg_gnt ? dbg_addr : cpu_addr;
    mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
  end

  // After a cap-forced release, dbg_lock must drop before another lock is taken.
  always_comb begin
    state_d      = state_q;
    relock_blk_d = relock_blk_q & dbg_lock;
    case (state_q)
      ARB: begin
        if (dbg_gnt && dbg_lock && !relock_blk_q) begin
          if (MAX_LOCK == 1) relock_blk_d = 1'b1;
          else               state_d      = LOCKED;
        end
      end
      LOCKED: begin
        if (!dbg_lock) begin
          state_d = ARB;
        end else if (dbg_gnt && lock_cnt == LW'(MAX_LOCK - 1)) begin
          state_d      = ARB;
          relock_blk_d = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    pend_d     = mem_en;
    owner_d    = dbg_gnt ? OWN_DBG : OWN_CPU;
    cpu_rvalid = pend_q && (owner_q == OWN_CPU);
    dbg_rvalid = pend_q && (owner_q == OWN_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      relock_blk_q <= 1'b0;
      pend_q       <= 1'b0;
      owner_q      <= OWN_CPU;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      relock_blk_q <= relock_blk_d;
      pend_q       <= pend_d;
      owner_q      <= owner_d;
      cpu_rdata_q  <= cpu_rdata;
      dbg_rdata_q  <= dbg_rdata;
    end
  end

  arb_wait_counter #(.MAX(MAX_WAIT), .W(WW)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (~dbg_req | dbg_gnt | locked),
    .en  (dbg_req & ~dbg_gnt & ~locked),
    .cnt (wait_cnt)
  );

  // Held clear in ARB so the locking grant itself loads a count of 1.
  arb_wait_counter #(.MAX(MAX_LOCK), .W(LW)) u_lock_cnt (
    .clk (clk),
    .rst (rst),
    .clr (~locked),
    .en  (dbg_gnt),
    .cnt (lock_cnt)
  );

endmodule
